// File: rtl/ofm_requant_packer.sv
// Requantizes the serialized PE-array result stream (bias, ReLU, rounding shift,
// 8-bit saturation) and packs four results per 32-bit word into an output FIFO.
module ofm_requant_packer #(
    parameter int DATA_WIDTH  = 16,
    parameter int TILING_SIZE = 8,
    parameter int NUM_OUT     = 4096,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                           clk1,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic [DATA_WIDTH-1:0]          ofm_in,
    input  logic                           valid_in,
    input  logic [3:0]                     shift,
    input  logic                           bias_wr_en,
    input  logic [$clog2(TILING_SIZE)-1:0] bias_wr_addr,
    input  logic [DATA_WIDTH-1:0]          bias_wr_data,
    output logic [31:0]                    out_word,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           overflow,
    output logic                           busy
);

    localparam int AW    = $clog2(TILING_SIZE);
    localparam int SUM_W = DATA_WIDTH + 2;
    localparam int FCW   = $clog2(NUM_OUT + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);

    logic signed [DATA_WIDTH-1:0] bias_r [TILING_SIZE];
    logic [AW-1:0]                ch_idx_r;
    logic [FCW-1:0]               frame_cnt_r;
    logic                         s1_valid_r;
    logic                         s1_last_r;
    logic signed [SUM_W-1:0]      s1_sum_r;
    logic                         s2_valid_r;
    logic                         s2_last_r;
    logic [7:0]                   s2_byte_r;
    logic [1:0]                   pack_idx_r;
    logic [31:0]                  pack_buf_r;
    logic [32:0]                  fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0]                wr_ptr_r;
    logic [PW-1:0]                rd_ptr_r;
    logic [PW:0]                  count_r;
    logic                         overflow_r;

    logic signed [DATA_WIDTH-1:0] bias_sel_s;
    logic signed [SUM_W-1:0]      sum_s;
    logic                         sample_last_s;
    logic [31:0]                  pack_word_s;
    logic                         push_s;
    logic                         pop_s;
    logic                         full_s;
    logic                         wr_en_s;
    logic                         drop_s;
    logic [32:0]                  head_s;

    // ReLU, round-half-up right shift, then clamp to an unsigned byte
    function automatic logic [7:0] requant(input logic signed [SUM_W-1:0] sum,
                                           input logic [3:0] sh);
        logic [SUM_W:0] pos;
        logic [SUM_W:0] rnd;
        pos = {1'b0, sum};
        if (sum[SUM_W-1]) begin
            rnd = '0;
        end else if (sh == 4'd0) begin
            rnd = pos;
        end else begin
            rnd = (pos + ((SUM_W+1)'(1'b1) << (sh - 4'd1))) >> sh;
        end
        if (rnd > (SUM_W+1)'(8'd255)) begin
            requant = 8'hFF;
        end else begin
            requant = rnd[7:0];
        end
    endfunction

    assign bias_sel_s    = bias_r[ch_idx_r];
    assign sum_s         = $signed({2'b00, ofm_in}) + $signed({{2{bias_sel_s[DATA_WIDTH-1]}}, bias_sel_s});
    assign sample_last_s = (frame_cnt_r == FCW'(NUM_OUT - 1));

    // Bias register file; survives clr, only rst_n zeroes it
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TILING_SIZE; i++) bias_r[i] <= '0;
        end else if (bias_wr_en) begin
            bias_r[bias_wr_addr] <= bias_wr_data;
        end
    end

    // Input side: channel/frame counters and stage-1 bias add
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            ch_idx_r    <= '0;
            frame_cnt_r <= '0;
            s1_valid_r  <= 1'b0;
            s1_last_r   <= 1'b0;
            s1_sum_r    <= '0;
        end else if (clr) begin
            ch_idx_r    <= '0;
            frame_cnt_r <= '0;
            s1_valid_r  <= 1'b0;
            s1_last_r   <= 1'b0;
            s1_sum_r    <= '0;
        end else begin
            s1_valid_r <= valid_in;
            s1_last_r  <= valid_in & sample_last_s;
            s1_sum_r   <= sum_s;
            if (valid_in) begin
                if (sample_last_s) begin
                    ch_idx_r    <= '0;
                    frame_cnt_r <= '0;
                end else begin
                    ch_idx_r    <= (ch_idx_r == AW'(TILING_SIZE - 1)) ? '0 : ch_idx_r + AW'(1'b1);
                    frame_cnt_r <= frame_cnt_r + FCW'(1'b1);
                end
            end
        end
    end

    // Stage 2: requantized byte
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
            s2_byte_r  <= 8'd0;
        end else if (clr) begin
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
            s2_byte_r  <= 8'd0;
        end else begin
            s2_valid_r <= s1_valid_r;
            s2_last_r  <= s1_last_r;
            s2_byte_r  <= requant(s1_sum_r, shift);
        end
    end

    // Merge the current byte into the partially packed word
    always_comb begin
        pack_word_s = pack_buf_r;
        case (pack_idx_r)
            2'd0:    pack_word_s[7:0]   = s2_byte_r;
            2'd1:    pack_word_s[15:8]  = s2_byte_r;
            2'd2:    pack_word_s[23:16] = s2_byte_r;
            2'd3:    pack_word_s[31:24] = s2_byte_r;
            default: pack_word_s        = pack_buf_r;
        endcase
    end

    assign push_s  = s2_valid_r & ((pack_idx_r == 2'd3) | s2_last_r);
    assign pop_s   = (count_r != '0) & out_ready;
    assign full_s  = (count_r == (PW+1)'(FIFO_DEPTH));
    assign wr_en_s = push_s & (~full_s | pop_s);
    assign drop_s  = push_s & full_s & ~pop_s;

    // Pack lane index and word buffer; buffer is zeroed after each push
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pack_idx_r <= 2'd0;
            pack_buf_r <= 32'd0;
        end else if (clr) begin
            pack_idx_r <= 2'd0;
            pack_buf_r <= 32'd0;
        end else if (s2_valid_r) begin
            if (push_s) begin
                pack_idx_r <= 2'd0;
                pack_buf_r <= 32'd0;
            end else begin
                pack_idx_r <= pack_idx_r + 2'd1;
                pack_buf_r <= pack_word_s;
            end
        end
    end

    // FIFO storage: {last, word}; stale entries are masked by the output gating
    always_ff @(posedge clk1) begin
        if (wr_en_s) begin
            fifo_mem_r[wr_ptr_r] <= {s2_last_r, pack_word_s};
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else if (clr) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            if (pop_s)   rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1'b1);
                2'b01:   count_r <= count_r - (PW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
            if (drop_s) overflow_r <= 1'b1;
        end
    end

    assign head_s    = fifo_mem_r[rd_ptr_r];
    assign out_valid = (count_r != '0);
    assign out_word  = out_valid ? head_s[31:0] : 32'd0;
    assign out_last  = out_valid & head_s[32];
    assign overflow  = overflow_r;
    assign busy      = (frame_cnt_r != '0) | s1_valid_r | s2_valid_r | (pack_idx_r != 2'd0) | out_valid;

endmodule

// File: doc/ofm_requant_packer.md
Name: ofm_requant_packer

Overview:
- Downstream stage of the fully-connected tile datapath.
- Consumes the serialized 16-bit partial-sum stream (`ofm` with `valid_data`) produced by the PE array and output mux.
- For each result: adds a per-output-channel bias, applies ReLU, requantizes by a rounding right shift, and saturates to 8 bits.
- Packs four results per 32-bit word into an output FIFO with a valid/ready interface toward the memory writer.

Parameters:
- DATA_WIDTH, 16, width of incoming ofm samples (unsigned) and of bias entries (signed).
- TILING_SIZE, 8, number of output channels per tile; size of the bias register file.
- NUM_OUT, 4096, results per frame (one kernel pass); the final word of a frame is flagged last.
- FIFO_DEPTH, 8, output word FIFO depth; power of two.

Ports:
- clk1 input 1 — clock.
- rst_n input 1 — reset.
- clr input 1 — synchronous soft clear.
- ofm_in input DATA_WIDTH — result sample, unsigned.
- valid_in input 1 — ofm_in valid; no backpressure upstream.
- shift input 4 — requant right-shift amount, 0..15; must be stable within a frame.
- bias_wr_en input 1 — bias register write strobe.
- bias_wr_addr input clog2(TILING_SIZE) — bias entry index.
- bias_wr_data input DATA_WIDTH — signed bias value.
- out_word output 32 — packed word; byte0 is the earliest result.
- out_last output 1 — qualifies out_word as the final word of a frame.
- out_valid output 1 — FIFO non-empty.
- out_ready input 1 — consumer accepts out_word.
- overflow output 1 — sticky; a word was dropped.
- busy output 1 — high while a frame is partially received or the pipeline/FIFO holds data.

Behaviour:

Clock and reset:
- Single clock clk1.
- Reset is asynchronous, active-low: rst_n.
- Reset values: all bias entries 0; channel index 0; frame counter 0; pack byte index 0; FIFO empty.
- Output reset values: out_valid=0, out_word=0, out_last=0, overflow=0, busy=0.

Soft clear (clr):
- Same effect as reset except bias entries are retained.
- clr has priority over valid_in in the same cycle; a sample presented with clr is discarded.

Channel index:
- Advances on each accepted sample and wraps TILING_SIZE-1 -> 0.
- Selects the bias entry applied to that sample.
- On a bias write to the index in use in the same cycle, the sample uses the old value; the new value applies from the next cycle.

Stage 1, registered on the edge that samples valid_in:
- sum = zero-extended ofm_in + sign-extended bias, held as a signed DATA_WIDTH+2 value. No overflow is possible at this width.

Stage 2, registered:
- ReLU: if sum < 0, then r = 0.
- Rounding: if shift > 0, r = (sum + 2^(shift-1)) >> shift; if shift = 0, r = sum.
- Saturation: r > 255 gives 255.

Stage 3, pack/push:
- The result is written into byte lane = pack index; the pack index then increments.
- When the 4th byte is filled, or when the frame counter reaches NUM_OUT, the word is pushed to the FIFO.
- Unfilled lanes of a final partial word are 0.
- The last bit is stored alongside each word and is set only on the frame-final word.
- After the frame-final word: frame counter, channel index and pack index all return to 0.

Latency:
- Take edge t as the edge sampling the 4th (or frame-final) sample.
- Stage 1 registers at t, stage 2 at t+1, the FIFO write occurs at t+2.
- With the FIFO previously empty, out_valid is high after edge t+2.
- Full-rate input (valid_in every cycle) is sustained indefinitely provided out_ready stays high.

Output handshake:
- out_word and out_last come from the FIFO head and are stable while out_valid=1 and out_ready=0.
- A pop occurs on out_valid & out_ready.
- Push and pop in the same cycle are both performed, including when the FIFO is full: no drop, and count is unchanged.

Overflow:
- A push while the FIFO is full, without a simultaneous pop, drops the new word.
- overflow is set and stays set until reset or clr.
- FIFO contents are unaffected.

Busy:
- busy = frame counter ≠ 0, OR any pipeline stage valid, OR FIFO non-empty.

Test Plan:
1. Pass-through: shift=0, all biases 0, ofm_in 10,20,30,40 on consecutive cycles -> one word 0x281E140A; out_valid rises 3 edges after the 4th sample; out_last=0.
2. Saturation and rounding: shift=2, inputs 6, 5, 0x0400, 1 -> bytes 2, 1, 255, 0 -> word 0x00FF0102.
3. Bias and ReLU: bias[0]=-100, bias[1]=+7, shift=0, inputs 50, 250, 50, 250 (channels 0..3) -> bytes 0, 255, 50, 250 -> word 0xFA32FF00. Also write bias[2] in the same cycle its sample arrives -> old bias used.
4. Partial frame: NUM_OUT=6, inputs 1..6 -> words 0x04030201 (last=0) then 0x00000605 (last=1); busy drops once both words are popped.
5. Backpressure: out_ready=0, push 9 words with FIFO_DEPTH=8 -> overflow=1, first 8 words intact; raise out_ready -> 8 words drain in order, then out_valid=0.
6. Clear/reset: clr mid-frame after 2 samples, then 4 new samples -> only the new word emitted, biases retained. Async rst_n mid-stream -> all outputs 0 immediately and biases 0.
